// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
//   Lets two independent requesters share one combinational ALU.
//   Requests are taken through valid/ready handshakes with round-robin
//   arbitration. Operands and opcode are registered into the ALU, and the
//   result and zero flag are captured one cycle later. The response is then
//   held until it is consumed. Only one operation is in flight at a time.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   reqN_valid/ready/op/a/b          requester N operation handshake (N=0,1)
//   alu_a, alu_b, alu_op             registered ALU inputs
//   alu_result, alu_zero             combinational ALU outputs
//   resp_valid/ready                 held response handshake
//   resp_id, resp_result, resp_zero  captured response fields
//   resp_illegal                     opcode was outside {0,1,2,6,7,12}
module alu_share_ctrl #(
    parameter int WIDTH = 64,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   id;
    logic   grant0;
    logic   grant1;

    function automatic logic op_illegal(input logic [OPW-1:0] op);
        case (op)
            OPW'(0), OPW'(1), OPW'(2), OPW'(6), OPW'(7), OPW'(12): return 1'b0;
            default:                                                return 1'b1;
        endcase
    endfunction

    // Round-robin: under contention the requester not granted last time wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && (!req1_valid || last_grant)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    // rst_n gates only the outputs so readies read 0 while reset is held;
    // the internal grants feeding the flops stay free of the reset net.
    assign req0_ready = grant0 & rst_n;
    assign req1_ready = grant1 & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            id           <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            resp_valid   <= 1'b0;
            resp_id      <= 1'b0;
            resp_result  <= '0;
            resp_zero    <= 1'b0;
            resp_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        alu_a      <= grant1 ? req1_a  : req0_a;
                        alu_b      <= grant1 ? req1_b  : req0_b;
                        alu_op     <= grant1 ? req1_op : req0_op;
                        id         <= grant1;
                        last_grant <= grant1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    resp_result  <= alu_result;
                    resp_zero    <= alu_zero;
                    resp_id      <= id;
                    resp_illegal <= op_illegal(alu_op);
                    resp_valid   <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl
//   Directed-vector bench for alu_share_ctrl. A small behavioural ALU closes
//   the loop on alu_a/alu_b/alu_op; expected responses are hand-computed
//   constants. Inputs change on the falling edge, and outputs are sampled 1
//   time unit later.
module tb_alu_share_ctrl;

    localparam int WIDTH = 64;
    localparam int OPW   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid, req0_ready;
    logic [OPW-1:0]   req0_op;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready;
    logic [OPW-1:0]   req1_op;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic [OPW-1:0]   alu_op;
    logic             alu_zero;
    logic             resp_valid, resp_ready, resp_id, resp_zero, resp_illegal;
    logic [WIDTH-1:0] resp_result;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    alu_share_ctrl #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_op      (req0_op),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_op      (req1_op),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_result  (resp_result),
        .resp_zero    (resp_zero),
        .resp_illegal (resp_illegal)
    );

    always #5 clk = ~clk;

    // Shared ALU: undefined opcodes return 0.
    always_comb begin
        case (alu_op)
            4'd0:    alu_result = alu_a & alu_b;
            4'd1:    alu_result = alu_a | alu_b;
            4'd2:    alu_result = alu_a + alu_b;
            4'd6:    alu_result = alu_a - alu_b;
            4'd7:    alu_result = alu_b;
            4'd12:   alu_result = ~(alu_a | alu_b);
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input bit who, input logic v, input logic [OPW-1:0] op,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (who) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    // Issue one op from an IDLE falling edge with resp_ready=1 and check
    // accept, registered ALU inputs and the response at T+2.
    task automatic do_op(input string tag, input bit who, input logic [OPW-1:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] exp_res, input bit exp_zero, input bit exp_ill);
        int unsigned n;
        set_req(who, 1'b1, op, a, b);
        #1;
        n = 0;
        while (!(who ? req1_ready : req0_ready) && n < 8) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, ".wait"},        n, 0);
        chk({tag, ".ready"},       who ? req1_ready : req0_ready, 1);
        chk({tag, ".other_ready"}, who ? req0_ready : req1_ready, 0);
        @(negedge clk);
        set_req(who, 1'b0, '0, '0, '0);
        #1;
        chk({tag, ".alu_a"},      alu_a, a);
        chk({tag, ".alu_b"},      alu_b, b);
        chk({tag, ".alu_op"},     alu_op, op);
        chk({tag, ".exec_valid"}, resp_valid, 0);
        @(negedge clk); #1;
        chk({tag, ".resp_valid"}, resp_valid, 1);
        chk({tag, ".result"},     resp_result, exp_res);
        chk({tag, ".zero"},       resp_zero, exp_zero);
        chk({tag, ".id"},         resp_id, who);
        chk({tag, ".illegal"},    resp_illegal, exp_ill);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".alu_a"},   alu_a, 0);
        chk({tag, ".alu_b"},   alu_b, 0);
        chk({tag, ".alu_op"},  alu_op, 0);
        chk({tag, ".rvalid"},  resp_valid, 0);
        chk({tag, ".rid"},     resp_id, 0);
        chk({tag, ".rresult"}, resp_result, 0);
        chk({tag, ".rzero"},   resp_zero, 0);
        chk({tag, ".rill"},    resp_illegal, 0);
        chk({tag, ".ready0"},  req0_ready, 0);
        chk({tag, ".ready1"},  req1_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        resp_ready = 1'b1;
        set_req(0, 1'b1, 4'd2, 64'd5, 64'd7);   // valid during reset must not see ready
        set_req(1, 1'b0, '0, '0, '0);

        // Reset values
        @(negedge clk); @(negedge clk); #1;
        chk_all_zero("reset");
        set_req(0, 1'b0, '0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single ADD, SUB to zero, wrap-around
        do_op("add",  0, 4'd2, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0);
        do_op("sub0", 1, 4'd6, 64'h10, 64'h10, 64'd0, 1'b1, 1'b0);
        do_op("wrap", 1, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0);

        // Contention: last grant was requester 1, so order is 0,1,0,1
        set_req(0, 1'b1, 4'd2, 64'd1, 64'd1);   // result 2
        set_req(1, 1'b1, 4'd0, 64'd3, 64'd5);   // result 1
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("fair%0d.ready0", k), req0_ready, (k % 2) == 0);
            chk($sformatf("fair%0d.ready1", k), req1_ready, (k % 2) == 1);
            @(negedge clk); #1;
            chk($sformatf("fair%0d.exec_rdy", k), {req0_ready, req1_ready}, 0);
            @(negedge clk); #1;
            chk($sformatf("fair%0d.resp_rdy", k), {req0_ready, req1_ready}, 0);
            chk($sformatf("fair%0d.valid", k),    resp_valid, 1);
            chk($sformatf("fair%0d.id", k),       resp_id, k % 2);
            chk($sformatf("fair%0d.result", k),   resp_result, (k % 2) == 1 ? 64'd1 : 64'd2);
            @(negedge clk);
        end
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);

        // Backpressure: NOR 0,0 held 5 cycles; requester 1 waits meanwhile
        resp_ready = 1'b0;
        set_req(0, 1'b1, 4'd12, 64'd0, 64'd0);
        #1;
        chk("bp.ready0", req0_ready, 1);
        @(negedge clk);
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b1, 4'd7, 64'd0, 64'hABCD);
        #1;
        chk("bp.exec_ready1", req1_ready, 0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp%0d.valid", i),  resp_valid, 1);
            chk($sformatf("bp%0d.result", i), resp_result, 64'hFFFF_FFFF_FFFF_FFFF);
            chk($sformatf("bp%0d.zero", i),   resp_zero, 0);
            chk($sformatf("bp%0d.id", i),     resp_id, 0);
            chk($sformatf("bp%0d.rdy", i),    {req0_ready, req1_ready}, 0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        chk("bp.last_valid", resp_valid, 1);
        @(negedge clk); #1;
        chk("bp.idle_valid",  resp_valid, 0);
        chk("bp.idle_ready1", req1_ready, 1);
        @(negedge clk);
        set_req(1, 1'b0, '0, '0, '0);
        @(negedge clk); #1;
        chk("bp.pass_result", resp_result, 64'hABCD);
        chk("bp.pass_id",     resp_id, 1);
        @(negedge clk);

        // Illegal opcode
        do_op("illegal", 0, 4'd3, 64'd1, 64'd1, 64'd0, 1'b1, 1'b1);

        // Reset during EXEC; last grant before reset is requester 0
        set_req(0, 1'b1, 4'd2, 64'd5, 64'd7);
        #1;
        chk("rst.accept", req0_ready, 1);
        @(negedge clk);
        set_req(1, 1'b1, 4'd0, 64'd3, 64'd5);
        #1;
        chk("rst.exec_a", alu_a, 64'd5);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_exec");
        @(negedge clk); #1;
        chk("rst.held_valid", resp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.rel_ready0", req0_ready, 1);
        chk("rst.rel_ready1", req1_ready, 0);
        chk("rst.rel_valid",  resp_valid, 0);
        @(negedge clk);
        set_req(0, 1'b0, '0, '0, '0);
        #1;
        chk("rst.exec_valid", resp_valid, 0);
        @(negedge clk); #1;
        chk("rst.resp_valid",  resp_valid, 1);
        chk("rst.resp_id",     resp_id, 0);
        chk("rst.resp_result", resp_result, 64'd12);
        @(negedge clk); #1;
        chk("rst.next_ready1", req1_ready, 1);
        @(negedge clk);
        set_req(1, 1'b0, '0, '0, '0);
        @(negedge clk); #1;
        chk("rst.next_result", resp_result, 64'd1);
        chk("rst.next_id",     resp_id, 1);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencing controller that shares the single 64-bit ALU between two independent requesters, such as the execute stage and a multi-cycle address/compare helper. It accepts operations through valid/ready handshakes and arbitrates round-robin. It registers the operands and opcode driven into the ALU, then captures the ALU result and zero flag. It returns them with the requester ID through a held response handshake, and serialises at most one operation at a time.

## Interface
Parameters:
- WIDTH, 64, operand/result width (matches ALU datapath).
- OPW, 4, opcode width.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  OPW  ALU opcode (0 AND, 1 OR, 2 ADD, 6 SUB, 7 pass B, 12 NOR).
- req0_a, req0_b  in  WIDTH  operands.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- alu_a, alu_b  out  WIDTH  registered operands to ALU.
- alu_op  out  OPW  registered opcode to ALU.
- alu_result  in  WIDTH  combinational ALU result.
- alu_zero  in  1  ALU zero flag.
- resp_valid  out  1  response held.
- resp_ready  in  1  consumer accepts response.
- resp_id  out  1  requester that issued the op.
- resp_result  out  WIDTH  captured result.
- resp_zero  out  1  captured zero flag.
- resp_illegal  out  1  opcode was not one of {0,1,2,6,7,12}.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If any reqN_valid, grant one requester and assert its reqN_ready combinationally, in the same cycle, while in IDLE.
  - On the edge: latch a, b, op into alu_a/alu_b/alu_op; latch the grant into an id register; set last_grant; go to EXEC.
- Arbitration:
  - Only one valid: that requester wins.
  - Both valid: the requester that is not last_grant wins.
  - last_grant resets to 1, so requester 0 wins the first contention.
- EXEC (exactly 1 cycle):
  - ALU evaluates the registered inputs.
  - On the edge: resp_result←alu_result, resp_zero←alu_zero, resp_id←id, resp_illegal←(op∉{0,1,2,6,7,12}); go to RESP.
  - Illegal ops are still issued; the ALU returns 0, so resp_zero is 1.
- RESP:
  - resp_valid=1.
  - All resp_* fields stay stable until the cycle in which resp_ready=1.
  - On that edge, go to IDLE.
- req0_ready and req1_ready are 0 in EXEC and RESP and are never both 1.
- Requesters must hold op, a and b stable while valid is high and ready is low. The controller does not buffer unaccepted requests.
- Arithmetic is modulo 2^WIDTH, wrap-around is performed by the ALU, and the controller adds no overflow logic.

## Timing
- Reset (asynchronous, takes effect immediately) sets:
  - state=IDLE, last_grant=1.
  - alu_a=0, alu_b=0, alu_op=0.
  - resp_valid=0, resp_id=0, resp_result=0, resp_zero=0, resp_illegal=0.
  - req0_ready=0, req1_ready=0.
- Accept in cycle T → alu_* valid from T+1 → resp_valid first high in T+2.
- Minimum issue interval is 3 cycles: back-to-back accepts at T and T+3 when resp_ready is held 1.
- resp_ready high while resp_valid is low is ignored.
- A request asserted during EXEC/RESP waits; it is evaluated in the first IDLE cycle.
- Reset mid-operation (EXEC or RESP) abandons the operation; no response is produced after rst_n deasserts.
- Deasserting rst_n: first grant possible in the first rising edge after release.

## Test plan
- Single ADD: req0 op=2, a=5, b=7; resp_ready=1 → req0_ready in T, resp_valid in T+2 with result=12, zero=0, id=0, illegal=0.
- SUB to zero plus wrap: req1 op=6, a=b=0x10 → result=0, zero=1, id=1. Then op=2, a=0xFFFF_FFFF_FFFF_FFFF, b=1 → result=0, zero=1.
- Contention fairness: both requesters valid continuously, resp_ready=1 → grants 0,1,0,1 with accepts every 3 cycles and resp_id matching.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid with op=12, a=0, b=0 → resp_result=0xFFFF_FFFF_FFFF_FFFF held stable, no readies asserted, IDLE one cycle after resp_ready=1.
- Illegal op: op=3, a=1, b=1 → result=0, zero=1, illegal=1.
- Reset in EXEC: assert rst_n=0 one cycle after accept → all outputs 0 immediately. After release, the next request proceeds normally and requester 0 wins the first contention.
